// File: rtl/ps2_keymatrix_mapper_pkg.sv
// ps2_keymatrix_mapper_pkg: shared action codes, FSM states and lookup addressing for the key mapper
package ps2_keymatrix_mapper_pkg;
  typedef enum logic [1:0] {ACT_KEY = 2'd0, ACT_RESET = 2'd1, ACT_CLEAR = 2'd2, ACT_RSVD = 2'd3} action_t;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
  localparam int ACT_W = 2;
  localparam int ROW_LSB = 0;
  localparam logic [6:0] UNMAPPED_CODE = 7'h7f;
  // Scan codes with bit 7 set all share one map slot per extended/plain bank
  function automatic logic [7:0] lookup_addr(input logic ext, input logic [7:0] code);
    return {ext, code[7] ? UNMAPPED_CODE : code[6:0]};
  endfunction
endpackage

// File: rtl/ps2_keymatrix_mapper_if.sv
// ps2_keymatrix_mapper_if: PS2 key event strobe and key map write port
interface ps2_keymatrix_mapper_if #(parameter int MAP_W = 10);
  logic ps2_key__valid;
  logic ps2_key__extended;
  logic ps2_key__release;
  logic [7:0] ps2_key__key_number;
  logic map_write_enable;
  logic map_write_ready;
  logic [7:0] map_write_address;
  logic [MAP_W-1:0] map_write_data;
  modport master (
    output ps2_key__valid, ps2_key__extended, ps2_key__release, ps2_key__key_number,
    output map_write_enable, map_write_address, map_write_data,
    input map_write_ready
  );
  modport slave (
    input ps2_key__valid, ps2_key__extended, ps2_key__release, ps2_key__key_number,
    input map_write_enable, map_write_address, map_write_data,
    output map_write_ready
  );
endinterface

// File: rtl/ps2_keymatrix_mapper_ram.sv
// ps2_keymap_ram: 256-entry single-port key map RAM with registered read
module ps2_keymap_ram #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         we,
  input  logic [7:0]   addr,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [256];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
    else rdata <= mem[addr];
endmodule

// File: rtl/ps2_keymatrix_mapper.sv
// ps2_keymatrix_mapper: translates PS2 key events through a writable map into a key matrix and special actions
module ps2_keymatrix_mapper
  import ps2_keymatrix_mapper_pkg::*;
#(
  parameter int NUM_COLS = 10,
  parameter int NUM_ROWS = 8,
  parameter int COL_W = 4,
  parameter int ROW_W = 3,
  parameter int MAP_W = 3 + COL_W + ROW_W
) (
  input  logic                         clk,
  input  logic                         reset,
  ps2_keymatrix_mapper_if.slave        bus,
  input  logic                         keys_clear,
  output logic                         init_done,
  output logic [NUM_COLS*NUM_ROWS-1:0] keys_down,
  output logic [NUM_COLS-1:0]          column_active,
  output logic                         reset_pressed,
  output logic                         key_changed
);
  localparam int NK = NUM_COLS * NUM_ROWS;
  localparam int IDX_W = NK > 1 ? $clog2(NK) : 1;
  state_t state, state_nxt;
  logic [7:0] cnt, ram_addr;
  logic run, host_wr, ram_we, s1_valid, s1_release, used, rp_nxt;
  logic [MAP_W-1:0] ram_wdata, entry;
  logic [NK-1:0] keys_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] idx;
  action_t act;
  assign run = state == RUN;
  assign init_done = run;
  assign bus.map_write_ready = run && !bus.ps2_key__valid;
  assign host_wr = bus.map_write_enable && bus.map_write_ready;
  assign ram_we = !run || host_wr;
  assign ram_addr = !run ? cnt : host_wr ? bus.map_write_address
                  : lookup_addr(bus.ps2_key__extended, bus.ps2_key__key_number);
  assign ram_wdata = run ? bus.map_write_data : '0;
  ps2_keymap_ram #(.W(MAP_W)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(entry)
  );
  assign row = entry[ROW_LSB +: ROW_W];
  assign col = entry[ROW_W +: COL_W];
  assign act = action_t'(entry[ROW_W+COL_W +: ACT_W]);
  assign used = entry[MAP_W-1];
  assign idx = IDX_W'(int'(col) * NUM_ROWS + int'(row));
  always_ff @(posedge clk)
    if (reset) state <= INIT;
    else state <= state_nxt;
  always_comb state_nxt = (state == INIT && cnt == 8'hff) ? RUN : state;
  always_comb begin
    keys_nxt = keys_down;
    rp_nxt = reset_pressed;
    if (s1_valid && used) begin
      if (act == ACT_KEY && int'(col) < NUM_COLS && int'(row) < NUM_ROWS) keys_nxt[idx] = !s1_release;
      if (act == ACT_RESET) rp_nxt = !s1_release;
      if (act == ACT_CLEAR && !s1_release) begin
        keys_nxt = '0;
        rp_nxt = 1'b0;
      end
    end
  end
  // keys_clear overrides the applied event and is deliberately silent on key_changed
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      s1_valid <= 1'b0;
      s1_release <= 1'b0;
      keys_down <= '0;
      reset_pressed <= 1'b0;
      key_changed <= 1'b0;
    end else begin
      cnt <= run ? cnt : cnt + 8'd1;
      s1_valid <= run && bus.ps2_key__valid;
      s1_release <= bus.ps2_key__release;
      keys_down <= keys_clear ? '0 : keys_nxt;
      reset_pressed <= !keys_clear && rp_nxt;
      key_changed <= !keys_clear && (keys_nxt != keys_down || rp_nxt != reset_pressed);
    end
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign column_active[c] = |keys_down[c*NUM_ROWS +: NUM_ROWS];
  end
endmodule

// File: tb/tb_ps2_keymatrix_mapper.sv
// tb_ps2_keymatrix_mapper: table-driven, directed and randomised checks of the key mapper against a map/matrix model
module tb_ps2_keymatrix_mapper;
  logic clk = 1'b0, reset = 1'b1, keys_clear = 1'b0;
  logic init_done, reset_pressed, key_changed;
  logic [79:0] keys_down;
  logic [9:0] column_active;
  int errors = 0, checks = 0;
  ps2_keymatrix_mapper_if #(.MAP_W(10)) bus ();
  ps2_keymatrix_mapper #(.NUM_COLS(10), .NUM_ROWS(8), .COL_W(4), .ROW_W(3)) dut (
    .clk(clk), .reset(reset), .bus(bus), .keys_clear(keys_clear), .init_done(init_done),
    .keys_down(keys_down), .column_active(column_active), .reset_pressed(reset_pressed),
    .key_changed(key_changed)
  );
  always #5 clk = ~clk;

  typedef struct {logic ext; logic [7:0] code; logic rel; int idx; logic val; logic rp; logic chg;} vec_t;
  vec_t tbl[15];
  logic [9:0] m_map [256];
  logic [79:0] m_keys;
  logic [9:0] m_pend_e;
  logic m_rp, m_chg, m_pend, m_pend_rel;

  function automatic vec_t mk(input int e, c, r, i, v, p, h);
    vec_t t;
    t.ext = e[0]; t.code = 8'(c); t.rel = r[0]; t.idx = i; t.val = v[0]; t.rp = p[0]; t.chg = h[0];
    return t;
  endfunction

  function automatic logic [9:0] ent(input logic u, input int act, col, row);
    return {u, 2'(act), 4'(col), 3'(row)};
  endfunction

  task automatic check(input string n, input logic [79:0] a, input logic [79:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    m_keys = '0; m_rp = 1'b0; m_chg = 1'b0; m_pend = 1'b0; m_pend_rel = 1'b0; m_pend_e = '0;
    for (int i = 0; i < 256; i++) m_map[i] = '0;
  endtask

  task automatic compare_model();
    logic [9:0] ca;
    ca = '0;
    for (int i = 0; i < 80; i++) if (m_keys[i]) ca[4'(i / 8)] = 1'b1;
    check("keys_down", keys_down, m_keys);
    check("reset_pressed", 80'(reset_pressed), 80'(m_rp));
    check("key_changed", 80'(key_changed), 80'(m_chg));
    check("column_active", 80'(column_active), 80'(ca));
  endtask

  // One clock: drive inputs, advance the model by one edge, compare all outputs
  task automatic cycle(input logic v, ext, input logic [7:0] code, input logic rel, clr, we,
                       input logic [7:0] wa, input logic [9:0] wd);
    logic [79:0] ok;
    logic orp;
    int col, row;
    bus.ps2_key__valid = v; bus.ps2_key__extended = ext; bus.ps2_key__key_number = code;
    bus.ps2_key__release = rel; keys_clear = clr; bus.map_write_enable = we;
    bus.map_write_address = wa; bus.map_write_data = wd;
    #1 check("map_write_ready", 80'(bus.map_write_ready), 80'(!v));
    @(posedge clk);
    ok = m_keys; orp = m_rp;
    if (m_pend && m_pend_e[9]) begin
      col = int'(m_pend_e[6:3]); row = int'(m_pend_e[2:0]);
      case (m_pend_e[8:7])
        2'd0: if (col < 10) m_keys[7'(col * 8 + row)] = !m_pend_rel;
        2'd1: m_rp = !m_pend_rel;
        2'd2: if (!m_pend_rel) begin m_keys = '0; m_rp = 1'b0; end
        default: ;
      endcase
    end
    if (clr) begin m_keys = '0; m_rp = 1'b0; m_chg = 1'b0; end
    else m_chg = (m_keys != ok) || (m_rp != orp);
    m_pend = v; m_pend_rel = rel;
    m_pend_e = m_map[{ext, code[7] ? 7'h7f : code[6:0]}];
    if (we && !v) m_map[wa] = wd;
    #1 compare_model();
  endtask

  task automatic idle();
    cycle('0, '0, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic press(input logic ext, input logic [7:0] code, input logic rel);
    cycle('1, ext, code, rel, '0, '0, '0, '0);
    idle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [9:0] d);
    cycle('0, '0, '0, '0, '0, '1, a, d);
  endtask

  task automatic wait_init(input logic inject, output int n);
    n = 0;
    while (!init_done && n < 400) begin
      if (inject && n == 10) begin
        bus.ps2_key__valid = 1'b1; bus.ps2_key__key_number = 8'h1C;
        bus.map_write_enable = 1'b1; bus.map_write_address = 8'h05; bus.map_write_data = ent(1'b1, 0, 1, 0);
      end
      if (inject && n == 11) bus.ps2_key__valid = 1'b0;
      if (inject && n == 14) bus.map_write_enable = 1'b0;
      @(posedge clk);
      #1 n++;
      if (inject && n >= 11 && n <= 14) begin
        check("init_keys", keys_down, '0);
        check("init_changed", 80'(key_changed), '0);
        check("init_ready", 80'(bus.map_write_ready), '0);
      end
    end
  endtask

  initial begin
    int n;
    tbl[0] = mk(0, 'h1C, 0, 26, 1, 0, 1);
    tbl[1] = mk(0, 'h1C, 0, 26, 1, 0, 0);
    tbl[2] = mk(0, 'h1C, 1, 26, 0, 0, 1);
    tbl[3] = mk(1, 'h75, 0, 79, 1, 0, 1);
    tbl[4] = mk(0, 'h75, 0, 79, 1, 0, 0);
    tbl[5] = mk(0, 'h15, 0, 0, 1, 0, 1);
    tbl[6] = mk(0, 'h16, 0, 45, 1, 0, 1);
    tbl[7] = mk(0, 'h07, 0, 45, 1, 1, 1);
    tbl[8] = mk(0, 'h20, 0, 0, 1, 1, 0);
    tbl[9] = mk(0, 'h30, 0, 0, 1, 1, 0);
    tbl[10] = mk(0, 'h31, 0, 0, 1, 1, 0);
    tbl[11] = mk(0, 'h83, 0, 9, 1, 1, 1);
    tbl[12] = mk(0, 'h09, 0, 79, 0, 0, 1);
    tbl[13] = mk(0, 'h09, 1, 0, 0, 0, 0);
    tbl[14] = mk(0, 'h07, 1, 9, 0, 0, 0);
    bus.ps2_key__valid = 1'b0; bus.ps2_key__extended = 1'b0; bus.ps2_key__release = 1'b0;
    bus.ps2_key__key_number = '0; bus.map_write_enable = 1'b0; bus.map_write_address = '0;
    bus.map_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_keys", keys_down, '0);
    check("rst_rp", 80'(reset_pressed), '0);
    check("rst_changed", 80'(key_changed), '0);
    check("rst_init_done", 80'(init_done), '0);
    check("rst_ready", 80'(bus.map_write_ready), '0);
    reset = 1'b0;
    wait_init(1'b1, n);
    check("init_cycles", 80'(n), 80'(256));
    model_reset();
    press(1'b0, 8'h05, 1'b0);
    check("init_write_ignored", 80'(keys_down[8]), '0);

    wr(8'h1C, ent(1'b1, 0, 3, 2)); wr(8'hF5, ent(1'b1, 0, 9, 7));
    wr(8'h07, ent(1'b1, 1, 0, 0)); wr(8'h09, ent(1'b1, 2, 0, 0));
    wr(8'h15, ent(1'b1, 0, 0, 0)); wr(8'h16, ent(1'b1, 0, 5, 5));
    wr(8'h20, ent(1'b1, 0, 12, 1)); wr(8'h7F, ent(1'b1, 0, 1, 1));
    wr(8'h30, ent(1'b1, 3, 2, 2)); wr(8'h31, ent(1'b0, 0, 2, 2));
    for (int i = 0; i < 15; i++) begin
      press(tbl[i].ext, tbl[i].code, tbl[i].rel);
      check($sformatf("tbl%0d_bit", i), 80'(keys_down[7'(tbl[i].idx)]), 80'(tbl[i].val));
      check($sformatf("tbl%0d_rp", i), 80'(reset_pressed), 80'(tbl[i].rp));
      check($sformatf("tbl%0d_changed", i), 80'(key_changed), 80'(tbl[i].chg));
    end

    cycle('1, '0, 8'h31, '0, '0, '1, 8'h41, ent(1'b1, 0, 4, 4));
    idle();
    press(1'b0, 8'h41, 1'b0);
    check("deferred_write_dropped", 80'(keys_down[36]), '0);
    wr(8'h41, ent(1'b1, 0, 4, 4));
    press(1'b0, 8'h41, 1'b0);
    check("retried_write", 80'(keys_down[36]), 80'(1));

    press(1'b0, 8'h15, 1'b0);
    cycle('1, '0, 8'h16, '0, '0, '0, '0, '0);
    cycle('0, '0, '0, '0, '1, '0, '0, '0);
    check("clear_vs_press_keys", keys_down, '0);
    check("clear_vs_press_changed", 80'(key_changed), '0);

    cycle('1, '0, 8'h16, '0, '0, '0, '0, '0);
    cycle('0, '0, '0, '0, '0, '1, 8'h16, ent(1'b1, 2, 0, 0));
    check("inflight_lookup_old_entry", 80'(keys_down[45]), 80'(1));
    press(1'b0, 8'h16, 1'b0);
    check("rewritten_entry_clears", keys_down, '0);

    cycle('1, '0, 8'h15, '0, '0, '0, '0, '0);
    cycle('1, '0, 8'h1C, '0, '0, '0, '0, '0);
    idle();
    check("b2b_first", 80'(keys_down[0]), 80'(1));
    check("b2b_second", 80'(keys_down[26]), 80'(1));

    for (int i = 0; i < 600; i++) begin
      logic v, ext, e2, rel, clr, we;
      logic [7:0] code, wa;
      v = $urandom_range(0, 2) != 0;
      ext = 1'($urandom_range(0, 1));
      e2 = 1'($urandom_range(0, 1));
      rel = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 24) == 0;
      we = $urandom_range(0, 5) == 0;
      code = ($urandom_range(0, 4) == 0) ? 8'(128 + $urandom_range(0, 127)) : 8'(16 + $urandom_range(0, 7));
      wa = ($urandom_range(0, 9) == 0) ? {e2, 7'h7f} : {e2, 7'(16 + $urandom_range(0, 7))};
      cycle(v, ext, code, rel, clr, we, wa,
            ent($urandom_range(0, 7) != 0, ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
    end
    idle();

    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst_keys", keys_down, '0);
    check("midrun_rst_rp", 80'(reset_pressed), '0);
    check("midrun_rst_changed", 80'(key_changed), '0);
    check("midrun_rst_init_done", 80'(init_done), '0);
    check("midrun_rst_ready", 80'(bus.map_write_ready), '0);
    reset = 1'b0;
    wait_init(1'b0, n);
    check("reinit_cycles", 80'(n), 80'(256));
    model_reset();
    press(1'b0, 8'h1C, 1'b0);
    check("reinit_map_cleared", 80'(keys_down[26]), '0);
    check("reinit_no_change", 80'(key_changed), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
